pipe_reg_elastic: RTL and testbench

Parametrised elastic pipeline register slice for the RV32I core. It replaces fixed stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one valid/ready-handshaked slice that provides:
- a separate control field, zeroed on bubbles, and a data field that is held;
- synchronous flush and external stall;
- an optional 2-entry skid buffer that registers the ready path;
- a saturating counter of beats dropped by flushes.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_sat_counter.sv | 16 +
 rtl/pipe_reg_elastic.sv | 81 ++++++++
 tb/tb_pipe_reg_elastic.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the RV32I elastic pipeline register slices
package pipe_pkg;
    typedef enum logic [1:0] {PR_EMPTY, PR_ONE, PR_FULL} pr_state_t;
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] wb_sel;
        logic [2:0] mem_type;
    } exmem_ctrl_t;
    localparam int EXMEM_DATA_W = 165;
endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating event counter, adds 0..3 per cycle, never wraps
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic [1:0]       i_inc,
    output logic [CNT_W-1:0] o_cnt
);
    localparam int SW = (CNT_W > 2 ? CNT_W : 2) + 1;
    logic [SW-1:0] sum;
    assign sum = SW'(o_cnt) + SW'(i_inc);
    always_ff @(posedge i_clk or negedge i_arst_n)
        if (!i_arst_n) o_cnt <= '0;
        else o_cnt <= sum > SW'({CNT_W{1'b1}}) ? '1 : sum[CNT_W-1:0];
endmodule

// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: valid/ready pipeline slice with optional skid entry, flush and drop counter
module pipe_reg_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W              = 128,
    parameter int CTRL_W              = 8,
    parameter int SKID                = 1,
    parameter int CLEAR_DATA_ON_FLUSH = 0,
    parameter int CNT_W               = 16
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_flush,
    input  logic              i_stall,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [1:0]        o_occupancy,
    output logic [CNT_W-1:0]  o_drop_cnt
);
    pr_state_t         state, nxt;
    logic              ready_q, acc, take;
    logic [DATA_W-1:0] skid_d;
    logic [CTRL_W-1:0] skid_c;
    logic [1:0]        drop_inc;

    assign o_valid     = state != PR_EMPTY;
    assign o_occupancy = state;
    assign take        = o_valid & i_ready & ~i_stall;
    assign o_ready     = SKID != 0 ? ready_q : (~o_valid | take);
    assign acc         = i_valid & o_ready;
    assign drop_inc    = i_flush ? o_occupancy - 2'(take) + 2'(acc) : 2'd0;

    // Without a skid entry acc in ONE implies take, so FULL is never reached.
    always_comb
        nxt = i_flush ? PR_EMPTY :
              state == PR_EMPTY ? (acc ? PR_ONE : PR_EMPTY) :
              state == PR_ONE ? (acc & ~take ? PR_FULL : (~acc & take ? PR_EMPTY : PR_ONE)) :
              (take ? PR_ONE : PR_FULL);

    always_ff @(posedge i_clk or negedge i_arst_n)
        if (!i_arst_n) begin
            state   <= PR_EMPTY;
            ready_q <= 1'b1;
            o_data  <= '0;
            o_ctrl  <= '0;
            skid_d  <= '0;
            skid_c  <= '0;
        end else begin
            state   <= nxt;
            ready_q <= nxt != PR_FULL;
            if (i_flush) begin
                o_ctrl <= '0;
                if (CLEAR_DATA_ON_FLUSH != 0) o_data <= '0;
            end else if (acc & (state == PR_EMPTY | take)) begin
                o_data <= i_data;
                o_ctrl <= i_ctrl;
            end else if (take & state == PR_FULL) begin
                o_data <= skid_d;
                o_ctrl <= skid_c;
            end else if (take) begin
                o_ctrl <= '0;
            end
            if (acc & ~take & state == PR_ONE) begin
                skid_d <= i_data;
                skid_c <= i_ctrl;
            end
        end

    pipe_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .i_inc    (drop_inc),
        .o_cnt    (o_drop_cnt)
    );
endmodule

// File: tb/tb_pipe_reg_elastic.sv
// tb_pipe_reg_elastic: directed and random scoreboard checks of the skid slice
module tb_pipe_reg_elastic;
    localparam int DW = 16;
    localparam int CW = 8;
    localparam int NW = 2;

    logic i_clk = 0, i_arst_n = 0, i_flush = 0, i_stall = 0, i_valid = 0, i_ready = 0;
    logic [DW-1:0] i_data = '0;
    logic [CW-1:0] i_ctrl = '0;
    logic o_ready, o_valid;
    logic [DW-1:0] o_data;
    logic [CW-1:0] o_ctrl;
    logic [1:0] o_occupancy;
    logic [NW-1:0] o_drop_cnt;

    pipe_reg_elastic #(
        .DATA_W(DW), .CTRL_W(CW), .SKID(1), .CLEAR_DATA_ON_FLUSH(0), .CNT_W(NW)
    ) dut (
        .i_clk(i_clk), .i_arst_n(i_arst_n), .i_flush(i_flush), .i_stall(i_stall),
        .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_ctrl(i_ctrl),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_ctrl(o_ctrl),
        .o_occupancy(o_occupancy), .o_drop_cnt(o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    int compared = 0, mismatched = 0;
    logic [DW+CW-1:0] sb[$];
    int exp_drop = 0;
    logic [DW-1:0] last_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int occ, sum;
        logic acc, take;
        occ = sb.size();
        chk("occupancy", 32'(o_occupancy), 32'(occ));
        chk("valid", 32'(o_valid), 32'(occ != 0));
        chk("ready", 32'(o_ready), 32'(occ < 2));
        chk("drop_cnt", 32'(o_drop_cnt), 32'(exp_drop));
        if (occ != 0) begin
            chk("data", 32'(o_data), 32'(sb[0][DW+CW-1:CW]));
            chk("ctrl", 32'(o_ctrl), 32'(sb[0][CW-1:0]));
        end else begin
            chk("idle_data", 32'(o_data), 32'(last_data));
            chk("idle_ctrl", 32'(o_ctrl), 32'd0);
        end
        acc  = i_valid && occ < 2;
        take = occ != 0 && i_ready && !i_stall;
        if (i_flush) begin
            sum = exp_drop + occ - int'(take) + int'(acc);
            exp_drop = sum > (1 << NW) - 1 ? (1 << NW) - 1 : sum;
        end
        if (take) void'(sb.pop_front());
        if (i_flush) sb.delete();
        else if (acc) sb.push_back({i_data, i_ctrl});
        if (sb.size() != 0) last_data = sb[0][DW+CW-1:CW];
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d);
        i_valid = v;
        i_data  = d;
        i_ctrl  = d[7:0] | 8'h80;
    endtask

    initial begin
        #12;
        cycle();
        i_arst_n = 1;
        cycle();
        // streaming
        i_ready = 1;
        for (int i = 1; i <= 20; i++) begin
            drive(1, 16'(i));
            cycle();
        end
        drive(0, 0);
        cycle();
        cycle();
        // backpressure
        i_ready = 0;
        drive(1, 16'h11);
        cycle();
        drive(1, 16'h22);
        cycle();
        drive(0, 0);
        chk("bp_occ", 32'(o_occupancy), 32'd2);
        chk("bp_ready", 32'(o_ready), 32'd0);
        chk("bp_data", 32'(o_data), 32'h11);
        cycle();
        i_ready = 1;
        cycle();
        chk("bp_second", 32'(o_data), 32'h22);
        cycle();
        chk("bp_bubble_ctrl", 32'(o_ctrl), 32'd0);
        cycle();
        // flush while full
        i_ready = 0;
        drive(1, 16'h33);
        cycle();
        drive(1, 16'h44);
        cycle();
        drive(0, 0);
        i_flush = 1;
        cycle();
        i_flush = 0;
        chk("ff_valid", 32'(o_valid), 32'd0);
        chk("ff_data_held", 32'(o_data), 32'h33);
        chk("ff_drop", 32'(o_drop_cnt), 32'd2);
        cycle();
        // flush with incoming beat and take
        drive(1, 16'h55);
        cycle();
        drive(1, 16'h66);
        i_ready = 1;
        i_flush = 1;
        cycle();
        i_flush = 0;
        drive(0, 0);
        chk("fit_valid", 32'(o_valid), 32'd0);
        chk("fit_drop", 32'(o_drop_cnt), 32'd3);
        cycle();
        // stall holds contents, then stall plus flush
        i_stall = 1;
        drive(1, 16'h77);
        cycle();
        drive(0, 0);
        cycle();
        chk("stall_data", 32'(o_data), 32'h77);
        drive(1, 16'h88);
        cycle();
        drive(0, 0);
        chk("stall_full_ready", 32'(o_ready), 32'd0);
        i_flush = 1;
        cycle();
        i_flush = 0;
        i_stall = 0;
        chk("sf_valid", 32'(o_valid), 32'd0);
        chk("sf_drop_sat", 32'(o_drop_cnt), 32'd3);
        // repeated flushes stay saturated
        for (int k = 0; k < 2; k++) begin
            i_ready = 0;
            drive(1, 16'h90 + 16'(k));
            cycle();
            drive(1, 16'hA0 + 16'(k));
            cycle();
            drive(0, 0);
            i_flush = 1;
            cycle();
            i_flush = 0;
            chk("sat_drop", 32'(o_drop_cnt), 32'd3);
        end
        // random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom));
            i_ready = 1'($urandom_range(0, 1));
            i_stall = $urandom_range(0, 5) == 0;
            i_flush = $urandom_range(0, 20) == 0;
            cycle();
        end
        i_flush = 0;
        i_stall = 0;
        // async reset with two beats held
        i_ready = 0;
        drive(1, 16'hB1);
        cycle();
        drive(1, 16'hB2);
        cycle();
        drive(0, 0);
        chk("pre_rst_occ", 32'(o_occupancy), 32'd2);
        #3;
        i_arst_n = 0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_occ", 32'(o_occupancy), 32'd0);
        chk("rst_ctrl", 32'(o_ctrl), 32'd0);
        chk("rst_drop", 32'(o_drop_cnt), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        sb.delete();
        exp_drop = 0;
        last_data = '0;
        @(posedge i_clk);
        #1;
        i_arst_n = 1;
        chk("rst_ready", 32'(o_ready), 32'd1);
        cycle();
        i_ready = 1;
        drive(1, 16'hC3);
        cycle();
        drive(0, 0);
        cycle();
        cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
